// File: rtl/timer_pkg.sv
// Shared constants for the 16-bit timer counting core.
// Direction encoding matches the tcr_dir control bit.
package timer_pkg;

    localparam int unsigned TMR_WIDTH = 16;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [TMR_WIDTH-1:0] TCNT_MAX = {TMR_WIDTH{1'b1}};

endpackage

// File: rtl/timer_counter_tick_gen.sv
// Rising-edge detector for the prescaled clk_in, sampled as data in the pclk domain.
// Combinational tick in the cycle clk_in is first seen high; no backpressure.
module tick_gen (
    input  logic pclk,
    input  logic preset_n,
    input  logic clk_in,
    input  logic reconf,
    output logic tick
);

    logic clk_in_q;
    logic clk_in_d;

    // Parking the history high during reconfig means the release edge can never look like a rise.
    always_comb begin
        clk_in_d = clk_in;
        if (reconf) begin
            clk_in_d = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            clk_in_q <= 1'b0;
        end else begin
            clk_in_q <= clk_in_d;
        end
    end

    assign tick = clk_in & ~clk_in_q & ~reconf;

endmodule

// File: rtl/timer_counter.sv
// Up/down counter with load, sticky wrap flags and registered irq; tcnt moves on the edge a tick is seen.
// Priority reset > load > count; ticks arriving while disabled are dropped.
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TMR_WIDTH
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             clk_in,
    input  logic             tcr_reconf,
    input  logic             tcr_en,
    input  logic             tcr_dir,
    input  logic             tcr_load,
    input  logic [WIDTH-1:0] tdr,
    input  logic             ovf_ie,
    input  logic             udf_ie,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    output logic [WIDTH-1:0] tcnt,
    output logic             tsr_ovf,
    output logic             tsr_udf,
    output logic             tmr_irq
);

    logic             tick;
    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             irq_q, irq_d;
    logic             ovf_set;
    logic             udf_set;

    tick_gen u_tick_gen (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clk_in   (clk_in),
        .reconf   (tcr_reconf),
        .tick     (tick)
    );

    always_comb begin
        tcnt_d  = tcnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (tcr_load) begin
            tcnt_d = tdr;
        end else if (tcr_en && tick) begin
            if (tcr_dir == DIR_UP) begin
                tcnt_d  = tcnt_q + 1'b1;
                ovf_set = (tcnt_q == {WIDTH{1'b1}});
            end else begin
                tcnt_d  = tcnt_q - 1'b1;
                udf_set = (tcnt_q == '0);
            end
        end
    end

    // A set in the same cycle as its clear strobe wins.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        udf_d = udf_set | (udf_q & ~udf_clr);
        irq_d = (ovf_d & ovf_ie) | (udf_d & udf_ie);
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            tcnt_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            irq_q  <= irq_d;
        end
    end

    assign tcnt    = tcnt_q;
    assign tsr_ovf = ovf_q;
    assign tsr_udf = udf_q;
    assign tmr_irq = irq_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting core of the 16-bit timer; sits directly downstream of the prescaler that produces clk_in from pclk.
- Samples clk_in in the pclk domain and counts one step per detected rising edge of clk_in, up or down.
- Supports load from the data register, wrap-around with sticky overflow/underflow flags, and an interrupt request to the APB register block.
- Never uses clk_in as a clock; a single pclk domain only.

Parameters:
- WIDTH, 16, counter width in bits; all counter/load data buses are WIDTH wide.

Ports:
- pclk  input  1  system/APB clock; sole clock of the block
- preset_n  input  1  synchronous active-low reset, sampled on rising pclk
- clk_in  input  1  divided count clock from prescaler, treated as data
- tcr_reconf  input  1  control-register reconfiguration strobe (same signal seen by prescaler)
- tcr_en  input  1  count enable
- tcr_dir  input  1  0 = count up, 1 = count down
- tcr_load  input  1  single-cycle load strobe
- tdr  input  WIDTH  load value
- ovf_ie  input  1  overflow interrupt enable
- udf_ie  input  1  underflow interrupt enable
- ovf_clr  input  1  write-1-clear strobe for ovf flag
- udf_clr  input  1  write-1-clear strobe for udf flag
- tcnt  output  WIDTH  current count
- tsr_ovf  output  1  sticky overflow flag
- tsr_udf  output  1  sticky underflow flag
- tmr_irq  output  1  interrupt request

Behaviour:
- Clock/reset: one clock, pclk; reset is synchronous and active-low on preset_n. Reset values: tcnt = 0, tsr_ovf = 0, tsr_udf = 0, tmr_irq = 0, internal clk_in_q = 0.
- Edge detect: clk_in_q <= clk_in every pclk. tick = clk_in & ~clk_in_q (combinational). Counter updates on the same pclk edge at which clk_in is first sampled 1 after a 0. Latency from the clk_in rising transition to the tcnt change is one pclk edge.
- Reconfig: while tcr_reconf = 1, clk_in_q <= 1 and tick is masked. The prescaler forces its outputs high during reconfig, so no spurious tick occurs on reconfig entry or exit. The first tick comes on the next genuine 0->1 of clk_in.
- Priority per cycle: reset > tcr_load > counting.
- Load: tcr_load = 1 gives tcnt <= tdr on that edge. A coincident tick is discarded. Flags are not affected by a load. tcr_en is not required for a load.
- Count: tcr_en = 1 and tick = 1 and no load:
  - up: tcnt <= tcnt + 1 modulo 2^WIDTH; if tcnt == all-ones, tcnt wraps to 0 and tsr_ovf <= 1.
  - down: tcnt <= tcnt - 1 modulo 2^WIDTH; if tcnt == 0, tcnt wraps to all-ones and tsr_udf <= 1.
- tcr_en = 0: tcnt holds. Ticks are lost, not queued. clk_in_q keeps tracking clk_in, so a re-enable while clk_in is already high does not count.
- tcr_dir change takes effect on the next tick. No direction change is latched mid-tick.
- Flags: sticky until the matching clr strobe. If a set and a clear occur in the same cycle, the set wins (flag stays 1).
- tmr_irq registered: tmr_irq <= (next tsr_ovf & ovf_ie) | (next tsr_udf & udf_ie). It asserts on the same edge the flag sets and deasserts on the edge the flag clears or the enable drops.
- Reset mid-count: all state returns to reset values on that edge. A tick in that cycle is ignored.

Decomposition:
- Shared package timer_pkg holds:
  - TMR_WIDTH = 16
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - TCNT_MAX = all-ones
- One natural sub-module: tick_gen. It owns clk_in_q, the reconfig masking and the tick output.
- Counter, flags and irq stay in timer_counter.

Test Plan:
- Basic count: reset, cks = 00 (clk2), tcr_en = 1, dir up → tcnt increments by 1 every 2 pclk: 0, 1, 2, …; with clk16, one increment every 16 pclk.
- Overflow: load tdr = 16'hFFFE, count up 2 ticks → tcnt = FFFF then 0000, tsr_ovf = 1. With ovf_ie = 1, tmr_irq = 1 on the wrap edge. ovf_clr pulse → flag and irq drop next edge.
- Underflow and simultaneity: load 0, dir down, one tick → tcnt = FFFF, tsr_udf = 1. Then assert udf_clr on the cycle of a second underflow → tsr_udf stays 1.
- Load vs tick: assert tcr_load with tdr = 16'h1234 on a tick cycle → tcnt = 1234, with no +1 applied. Next tick gives 1235.
- Reconfig glitch: hold tcr_reconf 3 cycles mid-count while clk_in is forced high, then release → tcnt unchanged through release; counting resumes only after the next clk_in 0->1.
- Enable and reset: tcr_en = 0 for 10 ticks → tcnt frozen. Drop preset_n for one cycle mid-count → tcnt = 0, flags = 0, irq = 0 on that edge.
